// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared encodings for the ALU execute unit (ops, functs, controls, FSM)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_OR    = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b100;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  localparam logic [3:0] ALU_CTL_AND     = 4'b0000;
  localparam logic [3:0] ALU_CTL_OR      = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD     = 4'b0010;
  localparam logic [3:0] ALU_CTL_SLL     = 4'b0011;
  localparam logic [3:0] ALU_CTL_SRL     = 4'b0100;
  localparam logic [3:0] ALU_CTL_SUB     = 4'b0110;
  localparam logic [3:0] ALU_CTL_SLT     = 4'b0111;
  localparam logic [3:0] ALU_CTL_SLTU    = 4'b1011;
  localparam logic [3:0] ALU_CTL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
//  Module   : alu_decode
//  Brief    : Combinational (alu_op, funct) -> (alu_ctl, is_shift, legal) decoder
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       is_shift,
  output logic       legal
);

  always_comb begin
    alu_ctl  = ALU_CTL_ILLEGAL;
    is_shift = 1'b0;
    legal    = 1'b1;
    case (alu_op)
      ALU_OP_ADD: alu_ctl = ALU_CTL_ADD;
      ALU_OP_SUB: alu_ctl = ALU_CTL_SUB;
      ALU_OP_OR:  alu_ctl = ALU_CTL_OR;
      ALU_OP_AND: alu_ctl = ALU_CTL_AND;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  alu_ctl = ALU_CTL_ADD;
          FUNCT_SUB:  alu_ctl = ALU_CTL_SUB;
          FUNCT_AND:  alu_ctl = ALU_CTL_AND;
          FUNCT_OR:   alu_ctl = ALU_CTL_OR;
          FUNCT_SLT:  alu_ctl = ALU_CTL_SLT;
          FUNCT_SLTU: alu_ctl = ALU_CTL_SLTU;
          FUNCT_SLL: begin
            alu_ctl  = ALU_CTL_SLL;
            is_shift = 1'b1;
          end
          FUNCT_SRL: begin
            alu_ctl  = ALU_CTL_SRL;
            is_shift = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module   : alu_exec_unit
//  Brief    : EX-stage ALU with single-cycle ops and iterative sll/srl, valid/ready I/O
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               alu_op,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic [3:0]               alu_ctl,
  output logic                     illegal
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so a step of WIDTH is representable.
  localparam logic [SHW:0] c_STEP = (SHW+1)'(SHIFT_STEP);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       w_dec_ctl;
  logic             w_is_shift;
  logic             w_legal;
  logic [WIDTH-1:0] w_alu_res;
  logic [SHW:0]     w_step;
  logic [WIDTH-1:0] w_shifted;
  logic [SHW-1:0]   w_rem_next;

  alu_decode u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctl  (w_dec_ctl),
    .is_shift (w_is_shift),
    .legal    (w_legal)
  );

  // Shifts by zero complete here with result=a; illegal ops yield 0.
  always_comb begin
    w_alu_res = '0;
    case (w_dec_ctl)
      ALU_CTL_ADD:  w_alu_res = a + b;
      ALU_CTL_SUB:  w_alu_res = a - b;
      ALU_CTL_AND:  w_alu_res = a & b;
      ALU_CTL_OR:   w_alu_res = a | b;
      ALU_CTL_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_CTL_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_CTL_SLL,
      ALU_CTL_SRL:  w_alu_res = a;
      default:      w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_step     = ({1'b0, rem_q} >= c_STEP) ? c_STEP : {1'b0, rem_q};
    w_shifted  = (ctl_q == ALU_CTL_SLL) ? (work_q << w_step) : (work_q >> w_step);
    w_rem_next = rem_q - w_step[SHW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    result_d  = result_q;
    ctl_d     = ctl_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ctl_d     = w_dec_ctl;
          illegal_d = ~w_legal;
          if (w_legal && w_is_shift && (shamt != '0)) begin
            work_d  = a;
            rem_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            result_d = w_alu_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = w_shifted;
        rem_d  = w_rem_next;
        if (w_rem_next == '0) begin
          result_d = w_shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      ctl_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign alu_ctl   = ctl_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Brief    : Directed, table-driven self-checking bench for alu_exec_unit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [3:0]       alu_ctl;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic [3:0]  ctl;
    logic        ill;
    int          lat;
    int          hold;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  alu_exec_unit #(.WIDTH(WIDTH), .SHIFT_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .shamt     (shamt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .alu_ctl   (alu_ctl),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic busy_bad;
    logic hold_bad;
    @(negedge clk);
    chk($sformatf("v%0d in_ready before accept", idx), {31'd0, in_ready}, 32'd1);
    alu_op = v.op; funct = v.fn; shamt = v.sh; a = v.va; b = v.vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; shamt = 5'd7;
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d in_ready low while busy", idx), {31'd0, busy_bad}, 32'd0);
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, (v.res == 32'd0)});
    chk($sformatf("v%0d alu_ctl", idx), {28'd0, alu_ctl}, {28'd0, v.ctl});
    chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
    hold_bad = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_op = 3'b000; a = 32'h5; b = 32'h6;
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== v.res || alu_ctl !== v.ctl || illegal !== v.ill)
        hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    if (v.hold > 0)
      chk($sformatf("v%0d outputs stable while stalled", idx), {31'd0, hold_bad}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d out_valid drops after handshake", idx), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d in_ready after handshake", idx), {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t addv;
    //         op      funct      sh     a             b             result        ctl      ill  lat hold
    vecs[0]  = '{3'b100, 6'b100000, 5'd0,  32'd7,        32'd5,        32'd12,       4'b0010, 1'b0, 1, 0};
    vecs[1]  = '{3'b100, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd1,        4'b0111, 1'b0, 1, 0};
    vecs[2]  = '{3'b100, 6'b101011, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        4'b1011, 1'b0, 1, 0};
    vecs[3]  = '{3'b100, 6'b000000, 5'd9,  32'd1,        32'd0,        32'h200,      4'b0011, 1'b0, 4, 0};
    vecs[4]  = '{3'b100, 6'b000010, 5'd0,  32'h80000000, 32'd0,        32'h80000000, 4'b0100, 1'b0, 1, 0};
    vecs[5]  = '{3'b100, 6'b000010, 5'd31, 32'h80000000, 32'd0,        32'd1,        4'b0100, 1'b0, 9, 0};
    vecs[6]  = '{3'b110, 6'b100000, 5'd0,  32'd9,        32'd9,        32'd0,        4'b1111, 1'b1, 1, 5};
    vecs[7]  = '{3'b100, 6'b111111, 5'd0,  32'd9,        32'd9,        32'd0,        4'b1111, 1'b1, 1, 5};
    vecs[8]  = '{3'b000, 6'b000000, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        4'b0010, 1'b0, 1, 0};
    vecs[9]  = '{3'b001, 6'b000000, 5'd0,  32'd3,        32'd5,        32'hFFFFFFFE, 4'b0110, 1'b0, 1, 0};
    vecs[10] = '{3'b010, 6'b000000, 5'd0,  32'hF0,       32'h0F,       32'hFF,       4'b0001, 1'b0, 1, 0};
    vecs[11] = '{3'b011, 6'b000000, 5'd0,  32'hFF00,     32'h0FF0,     32'h0F00,     4'b0000, 1'b0, 1, 2};
    vecs[12] = '{3'b100, 6'b100010, 5'd0,  32'd10,       32'd3,        32'd7,        4'b0110, 1'b0, 1, 0};
    vecs[13] = '{3'b100, 6'b000000, 5'd4,  32'h12345678, 32'd0,        32'h23456780, 4'b0011, 1'b0, 2, 0};
    vecs[14] = '{3'b100, 6'b000000, 5'd31, 32'd3,        32'd0,        32'h80000000, 4'b0011, 1'b0, 9, 3};
    vecs[15] = '{3'b100, 6'b101010, 5'd0,  32'd5,        32'hFFFFFFFF, 32'd0,        4'b0111, 1'b0, 1, 0};
    addv     = '{3'b000, 6'b000000, 5'd0,  32'd1,        32'd1,        32'd2,        4'b0010, 1'b0, 1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct = '0; shamt = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd1);
    chk("reset alu_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Abort a long shift with an asynchronous reset, then confirm normal operation.
    @(negedge clk);
    alu_op = 3'b100; funct = 6'b000000; shamt = 5'd20; a = 32'd1; b = 32'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid-shift in_ready low", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort result", result, 32'd0);
    chk("abort zero", {31'd0, zero}, 32'd1);
    chk("abort alu_ctl", {28'd0, alu_ctl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no result after abort", {31'd0, out_valid}, 32'd0);
    run_vec(addv, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
